// File: rtl/pipelined_multiplier_hs.sv
// Streaming WIDTH x WIDTH multiplier, signed/unsigned per item, valid/ready.
// Optional sideband tag enabled by PIPE_MULT_TAG_EN.
`timescale 1ns/1ps
module pipelined_multiplier_hs #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 sgn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   z
`ifdef PIPE_MULT_TAG_EN
    ,
    input  logic [TAG_W-1:0]     tag_in,
    output logic [TAG_W-1:0]     tag_out
`endif
);

    localparam int PW = 2 * WIDTH;
    localparam int R  = (WIDTH + STAGES - 1) / STAGES;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || TAG_W < 1) begin : g_param_err
        $error("pipelined_multiplier_hs: illegal parameters");
    end

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] w_rdy;
    logic [STAGES-1:0] w_uv;
    logic              r_s    [STAGES];
    logic              w_us   [STAGES];
    logic [WIDTH-1:0]  r_x    [STAGES];
    logic [WIDTH-1:0]  r_y    [STAGES];
    logic [WIDTH-1:0]  w_ux   [STAGES];
    logic [WIDTH-1:0]  w_uy   [STAGES];
    logic [PW-1:0]     r_acc  [STAGES];
    logic [PW-1:0]     w_uacc [STAGES];
    logic [PW-1:0]     w_sum  [STAGES];
`ifdef PIPE_MULT_TAG_EN
    logic [TAG_W-1:0]  r_tag  [STAGES];
    logic [TAG_W-1:0]  w_utag [STAGES];
`endif

    // A stage can load if it or any stage after it is empty, or the sink drains.
    for (genvar k = 0; k < STAGES; k++) begin : g_rdy
        assign w_rdy[k] = out_ready | ~(&r_v[STAGES-1:k]);
    end

    always_comb begin : p_up
        w_uv[0]   = in_valid;
        w_us[0]   = sgn;
        w_ux[0]   = x;
        w_uy[0]   = y;
        w_uacc[0] = '0;
`ifdef PIPE_MULT_TAG_EN
        w_utag[0] = tag_in;
`endif
        for (int k = 1; k < STAGES; k++) begin
            w_uv[k]   = r_v[k-1];
            w_us[k]   = r_s[k-1];
            w_ux[k]   = r_x[k-1];
            w_uy[k]   = r_y[k-1];
            w_uacc[k] = r_acc[k-1];
`ifdef PIPE_MULT_TAG_EN
            w_utag[k] = r_tag[k-1];
`endif
        end
    end

    // Signed mode: sign-extended rows, top row weighs -2^(WIDTH-1) so it is subtracted.
    always_comb begin : p_sum
        logic [PW-1:0] w_row;
        w_row = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_sum[k] = w_uacc[k];
            for (int i = 0; i < WIDTH; i++) begin
                w_row = w_us[k] ? {{WIDTH{w_ux[k][WIDTH-1]}}, w_ux[k]}
                                : {{WIDTH{1'b0}}, w_ux[k]};
                w_row = w_row << i;
                if (i >= k * R && i < (k + 1) * R && w_uy[k][i]) begin
                    if (w_us[k] && i == WIDTH - 1)
                        w_sum[k] = w_sum[k] - w_row;
                    else
                        w_sum[k] = w_sum[k] + w_row;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_s[k]   <= 1'b0;
                r_x[k]   <= '0;
                r_y[k]   <= '0;
                r_acc[k] <= '0;
`ifdef PIPE_MULT_TAG_EN
                r_tag[k] <= '0;
`endif
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_rdy[k]) begin
                    r_v[k]   <= w_uv[k];
                    r_s[k]   <= w_us[k];
                    r_x[k]   <= w_ux[k];
                    r_y[k]   <= w_uy[k];
                    r_acc[k] <= w_sum[k];
`ifdef PIPE_MULT_TAG_EN
                    r_tag[k] <= w_utag[k];
`endif
                end
            end
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_v[STAGES-1];
    assign z         = r_acc[STAGES-1];
`ifdef PIPE_MULT_TAG_EN
    assign tag_out   = r_tag[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_multiplier_hs.sv
// Bench for pipelined_multiplier_hs: queue-based reference model plus directed
// scenarios (stream, signed, backpressure, bubble collapse, reset, tags).
`timescale 1ns/1ps
module tb_pipelined_multiplier_hs;
    localparam int W  = 4;
    localparam int S  = 3;
    localparam int TW = 4;
    localparam int PW = 2 * W;
`ifdef PIPE_MULT_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  x = '0;
    logic [W-1:0]  y = '0;
    logic          sgn = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] z;
    logic [TW-1:0] tag_in = '0;
    logic [TW-1:0] tag_out;

    pipelined_multiplier_hs #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
`ifdef PIPE_MULT_TAG_EN
        ,
        .tag_in    (tag_in),
        .tag_out   (tag_out)
`endif
    );
`ifndef PIPE_MULT_TAG_EN
    assign tag_out = '0;
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [PW-1:0] z;
        logic [TW-1:0] t;
        int            cyc;
    } item_t;

    item_t q[$];
    item_t olog[$];
    int    alog[$];

    function automatic logic [PW-1:0] model_mul(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic s);
        longint la, lb;
        la = s ? longint'($signed(a)) : longint'(a);
        lb = s ? longint'($signed(b)) : longint'(b);
        return PW'(la * lb);
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    // Reference: items in flight are a FIFO; in_ready is set by occupancy.
    always @(negedge clk) begin : p_cmp
        item_t o;
        if (!rst) begin
            chk("in_ready", 64'(in_ready), 64'(out_ready || q.size() < S));
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_valid_unexpected actual=1 expected=0");
                end else begin
                    chk("z", 64'(z), 64'(q[0].z));
                    chk("tag_out", 64'(tag_out), 64'(q[0].t));
                end
            end
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                o.z = z;
                o.t = tag_out;
                o.cyc = cyc;
                olog.push_back(o);
            end
            if (in_valid && in_ready) begin
                o.z = model_mul(x, y, sgn);
                o.t = tag_in & {TW{TAG_EN}};
                o.cyc = cyc;
                q.push_back(o);
                alog.push_back(cyc);
            end
        end
    end

    always @(posedge rst) q.delete();

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [TW-1:0] t, output int tries);
        logic acc;
        acc = 1'b0;
        tries = 0;
        in_valid = 1'b1;
        x = a;
        y = b;
        sgn = s;
        tag_in = t;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            tries++;
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=0 expected=1");
        end
        in_valid = 1'b0;
    endtask

    initial begin : global_timeout
        #300000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    int tr;
    logic saw_full;
    logic [PW-1:0] e1 [4] = '{8'd6, 8'd40, 8'd28, 8'd27};
    logic [PW-1:0] e2 [6] = '{8'h40, 8'hF9, 8'hC8, 8'd64, 8'd105, 8'd56};
    logic [W-1:0]  xa [6] = '{4'h8, 4'hF, 4'h7, 4'h8, 4'hF, 4'h7};
    logic [W-1:0]  ya [6] = '{4'h8, 4'h7, 4'h8, 4'h8, 4'h7, 4'h8};
    logic [W-1:0]  x3 [5] = '{4'd2, 4'd5, 4'd7, 4'd15, 4'd1};
    logic [W-1:0]  y3 [5] = '{4'd3, 4'd5, 4'd2, 4'd15, 4'd9};
    logic [PW-1:0] e3 [5] = '{8'd6, 8'd25, 8'd14, 8'd225, 8'd9};

    initial begin
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_z", 64'(z), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("model_s_m8_m8", 64'(model_mul(4'h8, 4'h8, 1'b1)), 64'h40);
        chk("model_s_m1_7", 64'(model_mul(4'hF, 4'h7, 1'b1)), 64'hF9);
        chk("model_u_15_7", 64'(model_mul(4'hF, 4'h7, 1'b0)), 64'd105);
        step(2);
        rst = 1'b0;
        step(1);

        // unsigned stream, latency, tags
        out_ready = 1'b1;
        olog.delete();
        alog.delete();
        send(4'd3, 4'd2, 1'b0, 4'd1, tr);
        send(4'd8, 4'd5, 1'b0, 4'd2, tr);
        send(4'd4, 4'd7, 1'b0, 4'd3, tr);
        send(4'd9, 4'd3, 1'b0, 4'd4, tr);
        step(6);
        chk("t1_count", 64'(olog.size()), 64'd4);
        for (int i = 0; i < 4 && i < olog.size(); i++) begin
            chk("t1_z", 64'(olog[i].z), 64'(e1[i]));
            chk("t1_consecutive", 64'(olog[i].cyc), 64'(olog[0].cyc + i));
`ifdef PIPE_MULT_TAG_EN
            chk("t6_tag", 64'(olog[i].t), 64'(i + 1));
`endif
        end
        if (olog.size() > 0 && alog.size() > 0)
            chk("t1_latency", 64'(olog[0].cyc - alog[0]), 64'(S));

        // signed then unsigned with the same operands
        olog.delete();
        for (int i = 0; i < 6; i++)
            send(xa[i], ya[i], (i < 3), 4'(i), tr);
        step(6);
        chk("t2_count", 64'(olog.size()), 64'd6);
        for (int i = 0; i < 6 && i < olog.size(); i++)
            chk("t2_z", 64'(olog[i].z), 64'(e2[i]));

        // backpressure
        olog.delete();
        saw_full = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(x3[i], y3[i], 1'b0, 4'(i), tr);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) break;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (!in_ready && out_valid) saw_full = 1'b1;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        step(8);
        chk("t3_saw_full", 64'(saw_full), 64'd1);
        chk("t3_count", 64'(olog.size()), 64'd5);
        for (int i = 0; i < 5 && i < olog.size(); i++)
            chk("t3_z", 64'(olog[i].z), 64'(e3[i]));

        // bubble collapse under stall
        olog.delete();
        out_ready = 1'b0;
        send(4'd3, 4'd3, 1'b0, 4'd5, tr);
        step(2);
        send(4'd2, 4'd7, 1'b0, 4'd6, tr);
        chk("t4_accept_tries", 64'(tr), 64'd1);
        step(1);
        out_ready = 1'b1;
        step(6);
        chk("t4_count", 64'(olog.size()), 64'd2);
        if (olog.size() == 2) begin
            chk("t4_z0", 64'(olog[0].z), 64'd9);
            chk("t4_z1", 64'(olog[1].z), 64'd14);
        end

        // reset mid-flight
        olog.delete();
        send(4'd5, 4'd5, 1'b0, 4'd7, tr);
        send(4'd6, 4'd6, 1'b0, 4'd8, tr);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_z", 64'(z), 64'd0);
        step(2);
        rst = 1'b0;
        step(6);
        chk("t5_no_stale", 64'(olog.size()), 64'd0);
        alog.delete();
        send(4'd6, 4'd4, 1'b0, 4'd9, tr);
        step(5);
        chk("t5_count", 64'(olog.size()), 64'd1);
        if (olog.size() == 1 && alog.size() == 1) begin
            chk("t5_z", 64'(olog[0].z), 64'd24);
            chk("t5_latency", 64'(olog[0].cyc - alog[0]), 64'(S));
        end

        // randomized mixed-mode traffic with random backpressure
        olog.delete();
        alog.delete();
        for (int c = 0; c < 800; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            x = W'($urandom);
            y = W'($urandom);
            sgn = 1'($urandom_range(0, 1));
            tag_in = TW'($urandom);
            if (c < 300)
                out_ready = ($urandom_range(0, 3) != 0);
            else
                out_ready = ($urandom_range(0, 3) == 0);
            step(1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(10);
        chk("rand_drained", 64'(q.size()), 64'd0);
        chk("rand_count", 64'(olog.size()), 64'(alog.size()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
